spm_drv: RTL and testbench
==========================

SPM_DRV -- requirements
Module: spm_drv

Interface
REQ-001 SHALL have parameter `bits`, default 32, giving operand width; legal range 2..64.
REQ-002 SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port `rst`, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port `in_valid`, input, 1 bit: operand pair offered.
REQ-005 SHALL have port `in_ready`, output, 1 bit: block can accept an operand pair.
REQ-006 SHALL have port `in_x`, input, `bits` bits: multiplicand, parallel.
REQ-007 SHALL have port `in_a`, input, `bits` bits: multiplier, parallel.
REQ-008 SHALL have port `mul_x`, output, 1 bit: bit-serial multiplicand to the serial/parallel multiplier core, LSB first.
REQ-009 SHALL have port `mul_a`, output, `bits` bits: parallel multiplier to the core, held stable for a whole operation.
REQ-010 SHALL have port `mul_y`, input, 1 bit: bit-serial product from the core, LSB first.
REQ-011 SHALL have port `out_valid`, output, 1 bit: product available.
REQ-012 SHALL have port `out_ready`, input, 1 bit: consumer takes the product.
REQ-013 SHALL have port `out_p`, output, 2*`bits` bits: unsigned product.
REQ-014 SHALL have port `busy`, output, 1 bit: high in RUN or DONE.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 SHALL drive in_ready high only in IDLE; SHALL accept an operand pair on a rising edge with in_valid=1 and in_ready=1.
REQ-017 On acceptance, SHALL load in_x into a 2*`bits` shift register (upper half zero), load in_a into mul_a, clear the step counter and the product register, and enter RUN.
REQ-018 In RUN, SHALL drive mul_x = shift register bit 0, then shift right with zero fill each cycle; run step c (0..2*`bits`) presents x bit c, zero for c≥`bits`.
REQ-019 Core timing contract: product bit k appears on mul_y in the cycle after x bit k is presented (1-cycle core latency).
REQ-020 SHALL, at the edge ending each run step c with 1≤c≤2*`bits`, shift mul_y into the product register MSB (shift right), giving product bits 0..2*`bits`-1 LSB-first.
REQ-021 RUN SHALL last exactly 2*`bits`+1 cycles; at the edge ending step 2*`bits`, SHALL enter DONE with out_valid=1.
REQ-022 Latency: out_valid SHALL rise 2*`bits`+1 rising edges after the accepting edge.
REQ-023 In DONE, SHALL hold out_valid=1 and out_p stable until a rising edge with out_ready=1, then enter IDLE.
REQ-024 SHALL drive mul_x=0 in IDLE and DONE; the zero-extended stream leaves the core state all-zero after each operation, so back-to-back operations need no core clear.
REQ-025 SHALL ignore in_valid outside IDLE; SHALL ignore out_ready outside DONE.
REQ-026 SHALL keep mul_a unchanged from acceptance until the next acceptance.
REQ-027 SHALL drive out_p from the product register in all states; its value is defined only while out_valid=1.
REQ-028 Maximum throughput: one product per 2*`bits`+3 cycles, with in_valid and out_ready held high.

Reset
REQ-029 While rst=1, SHALL asynchronously force state IDLE: in_ready=1, out_valid=0, busy=0, mul_x=0, mul_a=0, out_p=0, counter=0, shift register=0.
REQ-030 Reset during RUN or DONE SHALL abort the operation without producing out_valid; the core SHALL be reset from the same reset source so it restarts from an all-zero state.
REQ-031 The first acceptance SHALL be possible on the first rising edge after rst deasserts.

Verification (bits=8, bench core = behavioural 1-cycle-latency serial/parallel multiplier)
REQ-032 in_x=0xFF, in_a=0xFF -> out_p=0xFE01; out_valid rises exactly 17 edges after acceptance.
REQ-033 in_x=0x00, in_a=0xA5, then in_x=0x0D, in_a=0x0B -> out_p=0x0000, then 0x008F.
REQ-034 Back-to-back operations with in_valid=out_ready=1 held high, 3 random pairs -> each out_p matches in_x*in_a; period is 19 cycles.
REQ-035 out_ready held low for 10 cycles in DONE -> out_valid and out_p stable; in_ready=0; a new in_valid is not accepted.
REQ-036 rst pulse at run step 5, then in_x=0x03, in_a=0x05 -> no out_valid for the aborted operation; next out_p=0x000F.
REQ-037 in_valid toggled during RUN with changing in_x/in_a -> mul_a unchanged; result equals the originally accepted operands' product.

Source files
------------

// File: rtl/spm_drv.sv
// rtl/spm_drv.sv - operand/result driver for a bit-serial serial/parallel multiplier core
module spm_drv #(
    parameter int bits = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [bits-1:0]   in_x,
    input  logic [bits-1:0]   in_a,
    output logic              mul_x,
    output logic [bits-1:0]   mul_a,
    input  logic              mul_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*bits-1:0] out_p,
    output logic              busy
);

    localparam int PW = 2 * bits;
    localparam int CW = $clog2(PW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   sreg;
    logic [PW-1:0]   preg;
    logic [CW-1:0]   cnt;
    logic [bits-1:0] a_reg;

    // Step c of a run presents x bit c; the upper half of sreg is zero, so
    // steps bits..2*bits feed zeros and flush the core back to all-zero.
    assign mul_x = (state == RUN) & sreg[0];
    assign mul_a = a_reg;
    assign out_p = preg;

    // Control FSM with registered handshake flags, operand and product shifting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sreg      <= '0;
            preg      <= '0;
            cnt       <= '0;
            a_reg     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sreg     <= {{bits{1'b0}}, in_x};
                        a_reg    <= in_a;
                        cnt      <= '0;
                        preg     <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    sreg <= sreg >> 1;
                    cnt  <= cnt + 1'b1;
                    // The core answers one cycle late, so product bit c-1
                    // arrives during step c; step 0 carries no product bit.
                    if (cnt != '0) begin
                        preg <= {mul_y, preg[PW-1:1]};
                    end
                    if (cnt == CW'(PW)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spm_drv.sv
// tb/tb_spm_drv.sv - randomized self-checking bench for spm_drv with a behavioural core
module tb_spm_drv;

    localparam int B = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [B-1:0]   in_x;
    logic [B-1:0]   in_a;
    logic           mul_x;
    logic [B-1:0]   mul_a;
    logic           mul_y;
    logic           out_valid;
    logic           out_ready;
    logic [2*B-1:0] out_p;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    spm_drv #(.bits(B)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_a      (in_a),
        .mul_x     (mul_x),
        .mul_a     (mul_a),
        .mul_y     (mul_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural serial/parallel core: shift-add accumulator, one product
    // bit per cycle, registered so bit k appears the cycle after x bit k.
    logic [B-1:0] acc;
    logic [B:0]   core_sum;
    assign core_sum = {1'b0, acc} + (mul_x ? {1'b0, mul_a} : '0);
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            mul_y <= 1'b0;
        end else begin
            mul_y <= core_sum[0];
            acc   <= core_sum[B:1];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation: accept, optional input noise during RUN, hold in
    // DONE for `hold` cycles with a competing in_valid, then release.
    task automatic run_op(input logic [B-1:0] x, input logic [B-1:0] a,
                          input int hold, input bit noise);
        logic [2*B-1:0] exp_p;
        logic [2*B-1:0] held;
        int lat;
        exp_p = 16'(x) * 16'(a);
        in_valid  = 1'b1;
        in_x      = x;
        in_a      = a;
        out_ready = 1'b0;
        tick();
        check("accept_busy", busy, 1);
        check("accept_in_ready", in_ready, 0);
        check("accept_mul_a", mul_a, a);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (noise) begin
                in_valid = 1'($urandom);
                in_x     = B'($urandom);
                in_a     = B'($urandom);
            end
            tick();
            lat++;
        end
        check("latency", lat, 2*B+1);
        check("product", out_p, exp_p);
        check("run_mul_a", mul_a, a);
        held     = out_p;
        in_valid = 1'b1;
        in_x     = ~x;
        in_a     = ~a;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_p", out_p, held);
            check("hold_in_ready", in_ready, 0);
        end
        check("hold_mul_a", mul_a, a);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        check("release_busy", busy, 0);
    endtask

    logic [B-1:0] px [3];
    logic [B-1:0] pa [3];
    int           t_out [3];

    initial begin
        int n;
        int ov_seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_a      = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_mul_x", mul_x, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_out_p", out_p, 0);
        rst = 1'b0;

        // First acceptance on the first edge after reset release.
        run_op(8'hFF, 8'hFF, 0, 1'b0);
        run_op(8'h00, 8'hA5, 0, 1'b0);
        run_op(8'h0D, 8'h0B, 0, 1'b0);
        run_op(B'($urandom), B'($urandom), 10, 1'b0);

        // Back-to-back with both handshakes held high.
        for (int i = 0; i < 3; i++) begin
            px[i] = B'($urandom);
            pa[i] = B'($urandom);
        end
        in_x      = px[0];
        in_a      = pa[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b2b_mul_a", mul_a, pa[i]);
            if (i < 2) begin
                in_x = px[i+1];
                in_a = pa[i+1];
            end else begin
                in_valid = 1'b0;
            end
            n = 0;
            while (!out_valid && n < 100) begin
                tick();
                n++;
            end
            t_out[i] = cyc;
            check("b2b_latency", n, 2*B+1);
            check("b2b_product", out_p, 16'(px[i]) * 16'(pa[i]));
            tick();
            check("b2b_idle", in_ready, 1);
        end
        check("b2b_period_1", t_out[1] - t_out[0], 2*B+3);
        check("b2b_period_2", t_out[2] - t_out[1], 2*B+3);
        out_ready = 1'b0;

        // Operand noise during RUN must not disturb the accepted pair.
        for (int i = 0; i < 4; i++) begin
            run_op(B'($urandom), B'($urandom), $urandom_range(0, 3), 1'b1);
        end

        // Reset pulse at run step 5 aborts without a result.
        in_valid = 1'b1;
        in_x     = 8'hC3;
        in_a     = 8'h7E;
        tick();
        in_valid = 1'b0;
        ov_seen  = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid) ov_seen++;
        end
        rst = 1'b1;
        #2;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_mul_a", mul_a, 0);
        check("abort_out_p", out_p, 0);
        check("abort_no_result", ov_seen, 0);
        rst = 1'b0;
        run_op(8'h03, 8'h05, 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
